// File: rtl/diag_read_out.sv
// rtl/diag_read_out.sv - diagonal SRAM read-back with lane de-reversal, masking and credit-tracked output FIFO
module diag_read_out #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                    clk,
    input  logic                                    srst,
    input  logic                                    start,
    input  logic [1:0]                              data_set,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    sram_read_enable_a0,
    output logic [5:0]                              sram_raddr_a,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
    output logic                                    sram_read_enable_c0,
    output logic [5:0]                              sram_raddr_c,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_c,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] out_data,
    output logic [ARRAY_SIZE-1:0]                   out_mask,
    output logic [5:0]                              out_index,
    output logic                                    out_last
);
    localparam int N  = ARRAY_SIZE;
    localparam int W  = OUTPUT_DATA_WIDTH;
    localparam int NW = N * W;
    localparam int AW = 6;
    localparam int EW = NW + N + AW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] LAST_K = AW'(2 * N - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (2 * ARRAY_SIZE - 1 > 64) begin : g_size_check
        $error("diag_read_out: 2*ARRAY_SIZE-1 must fit a 6-bit address");
    end
    if (FIFO_DEPTH < 3 || (1 << PW) != FIFO_DEPTH) begin : g_depth_check
        $error("diag_read_out: FIFO_DEPTH must be a power of 2 and at least 3");
    end

    logic [1:0]    state;
    logic          bank_sel;
    logic [AW-1:0] next_k;
    logic          s1_v, s2_v;
    logic [AW-1:0] s1_k, s2_k;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] occ, occ_next;

    logic          start_ok, pop, push, credit, issue, bank_eff;
    logic [AW-1:0] issue_k;
    logic [NW-1:0] rd_sel, push_data;
    logic [N-1:0]  push_mask;
    logic [EW-1:0] head;

    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign push      = s2_v;
    assign start_ok  = (state == S_IDLE) && start && !data_set[1];
    assign bank_eff  = (state == S_IDLE) ? data_set[0] : bank_sel;
    assign issue_k   = (state == S_IDLE) ? '0 : next_k;
    // A credit released by this cycle's pop may be spent on this cycle's issue.
    assign credit    = (int'(occ) + int'(s1_v) + int'(s2_v) - int'(pop)) < FIFO_DEPTH;
    assign issue     = credit && (start_ok || state == S_READ);
    assign occ_next  = occ + CW'(push) - CW'(pop);
    assign rd_sel    = bank_sel ? sram_rdata_c : sram_rdata_a;

    always_comb begin
        push_mask = '0;
        push_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(s2_k) < N) push_mask[i] = (i <= int'(s2_k));
            else                push_mask[i] = (i < 2 * N - 1 - int'(s2_k));
            push_data[i*W +: W] = push_mask[i] ? rd_sel[(N-1-i)*W +: W] : '0;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state               <= S_IDLE;
            bank_sel            <= 1'b0;
            next_k              <= '0;
            s1_v                <= 1'b0;
            s2_v                <= 1'b0;
            s1_k                <= '0;
            s2_k                <= '0;
            wptr                <= '0;
            rptr                <= '0;
            occ                 <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            sram_read_enable_a0 <= 1'b1;
            sram_read_enable_c0 <= 1'b1;
            sram_raddr_a        <= '0;
            sram_raddr_c        <= '0;
        end else begin
            s1_v                <= issue;
            s1_k                <= issue_k;
            s2_v                <= s1_v;
            s2_k                <= s1_k;
            sram_read_enable_a0 <= !(issue && !bank_eff);
            sram_read_enable_c0 <= !(issue && bank_eff);
            sram_raddr_a        <= (issue && !bank_eff) ? issue_k : '0;
            sram_raddr_c        <= (issue && bank_eff) ? issue_k : '0;
            done                <= 1'b0;
            occ                 <= occ_next;
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        bank_sel <= data_set[0];
                        busy     <= 1'b1;
                        next_k   <= '0;
                        state    <= (issue && issue_k == LAST_K) ? S_DRAIN : S_READ;
                    end
                end
                S_READ: begin
                    if (issue && issue_k == LAST_K) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Finish once the last word has left and no read is still in the pipe.
                    if (occ_next == '0 && !s1_v) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue) next_k <= issue_k + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {push_data, push_mask, s2_k, s2_k == LAST_K};
    end

    assign head      = mem[rptr];
    assign out_data  = out_valid ? head[EW-1 -: NW]     : '0;
    assign out_mask  = out_valid ? head[AW+N : AW+1]    : '0;
    assign out_index = out_valid ? head[AW:1]           : '0;
    assign out_last  = out_valid ? head[0]              : 1'b0;
endmodule

// File: tb/tb_diag_read_out.sv
// tb/tb_diag_read_out.sv - directed self-checking bench for diag_read_out
module tb_diag_read_out;
    localparam int N  = 32;
    localparam int W  = 32;
    localparam int NW = N * W;
    localparam int NK = 2 * N - 1;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    data_set = 2'd0;
    logic          busy, done, en_a, en_c;
    logic [5:0]    addr_a, addr_c;
    logic [NW-1:0] rdata_a, rdata_c, out_data;
    logic          out_valid, out_last;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_mask;
    logic [5:0]    out_index;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [N-1:0] mask_seen [NK];

    always #5 clk = ~clk;

    diag_read_out #(.ARRAY_SIZE(N), .OUTPUT_DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .srst(srst), .start(start), .data_set(data_set),
        .busy(busy), .done(done),
        .sram_read_enable_a0(en_a), .sram_raddr_a(addr_a), .sram_rdata_a(rdata_a),
        .sram_read_enable_c0(en_c), .sram_raddr_c(addr_c), .sram_rdata_c(rdata_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_index(out_index), .out_last(out_last)
    );

    // Word k, slot s holds {k, s}; a non-strobed bank returns poison so wrong-bank reads show up.
    function automatic logic [NW-1:0] sram_word(input logic [5:0] a);
        logic [NW-1:0] w;
        for (int s = 0; s < N; s++) w[s*W +: W] = {16'h0, 2'b00, a, 8'(s)};
        return w;
    endfunction

    always @(posedge clk) begin
        rdata_a <= en_a ? {N{32'hDEADBEEF}} : sram_word(addr_a);
        rdata_c <= en_c ? {N{32'hDEADBEEF}} : sram_word(addr_c);
    end

    function automatic logic [N-1:0] exp_mask(input int k);
        logic [63:0] m;
        if (k < N) m = (64'd1 << (k + 1)) - 64'd1;
        else       m = (64'd1 << (2 * N - 1 - k)) - 64'd1;
        return m[N-1:0];
    endfunction

    function automatic logic [NW-1:0] exp_data(input int k);
        logic [NW-1:0] d;
        logic [N-1:0]  m;
        m = exp_mask(k);
        for (int i = 0; i < N; i++)
            d[i*W +: W] = m[i] ? {16'h0, 2'b00, 6'(k), 8'(N - 1 - i)} : 32'h0;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (#%0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic sweep(input int bank, input int mode, input int stall0, input int mid_start, input bit lat);
        int exp_k = 0, strobes = 0, other = 0, pops = 0, max_infl = 0;
        int last_hs = -1, done_cyc = -1, stable_err = 0;
        int first_hs [4];
        bit held = 1'b0, rdy, hs, act_en, oth_en;
        logic [NW+N+6:0] hold_v;
        for (int j = 0; j < 4; j++) first_hs[j] = -1;
        data_set = 2'(bank);
        start    = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 2000 && done_cyc < 0; cyc++) begin
            start    = (cyc == mid_start);
            data_set = (cyc == mid_start) ? 2'(1 - bank) : 2'(bank);
            act_en = (bank == 1) ? en_c : en_a;
            oth_en = (bank == 1) ? en_a : en_c;
            if (!act_en) strobes++;
            if (!oth_en) other++;
            if (strobes - pops > max_infl) max_infl = strobes - pops;
            if (lat && cyc == 1) begin
                chk("lat_strobe", act_en, 0);
                chk("lat_addr", (bank == 1) ? addr_c : addr_a, 0);
                chk("busy_on", busy, 1);
            end
            if (lat && cyc == 2) chk("lat_valid_c2", out_valid, 0);
            if (lat && cyc == 3) chk("lat_valid_c3", out_valid, 1);
            if (stall0 > 0 && cyc == stall0) begin
                chk("stall_strobes", strobes, 4);
                chk("stall_strobe_idle", act_en, 1);
            end
            if (held && out_valid && {out_data, out_mask, out_index, out_last} !== hold_v) stable_err++;
            if (cyc <= stall0)  rdy = 1'b0;
            else if (mode == 0) rdy = 1'b1;
            else                rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
            out_ready = rdy;
            hs = out_valid && rdy;
            if (done) done_cyc = cyc;
            if (hs) begin
                chk("index", out_index, exp_k);
                chk("data", out_data, exp_data(exp_k));
                chk("mask", out_mask, exp_mask(exp_k));
                chk("last", out_last, exp_k == NK - 1);
                if (exp_k < NK) mask_seen[exp_k] = out_mask;
                if (exp_k < 4) first_hs[exp_k] = cyc;
                if (exp_k == NK - 1) last_hs = cyc;
                exp_k++;
                pops++;
            end
            held   = out_valid && !rdy;
            hold_v = {out_data, out_mask, out_index, out_last};
            @(negedge clk);
        end
        start = 1'b0;
        chk("word_count", exp_k, NK);
        chk("done_timing", done_cyc, last_hs + 1);
        chk("inflight_max", max_infl <= 4, 1);
        chk("other_bank_idle", other, 0);
        chk("stall_stable", stable_err, 0);
        chk("done_pulse", done, 0);
        chk("busy_off", busy, 0);
        if (stall0 > 0) begin
            chk("burst_first", first_hs[0], stall0 + 1);
            chk("burst_fourth", first_hs[3], stall0 + 4);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en_a"}, en_a, 1);
        chk({tag, "_en_c"}, en_c, 1);
        chk({tag, "_addr_a"}, addr_a, 0);
        chk({tag, "_addr_c"}, addr_c, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_mask"}, out_mask, 0);
        chk({tag, "_index"}, out_index, 0);
    endtask

    initial begin
        int strobes, busy_seen, done_seen, waited;
        @(negedge clk);
        chk_reset_outputs("reset");
        srst = 1'b0;
        @(negedge clk);

        sweep(0, 0, 0, 0, 1'b1);
        chk("mask_k0", mask_seen[0], 32'h0000_0001);
        chk("mask_k31", mask_seen[31], 32'hFFFF_FFFF);
        chk("mask_k40", mask_seen[40], 32'h007F_FFFF);
        chk("mask_k62", mask_seen[62], 32'h0000_0001);

        sweep(1, 0, 0, 0, 1'b1);
        sweep(0, 1, 0, 0, 1'b0);
        sweep(1, 1, 0, 30, 1'b0);
        sweep(0, 0, 20, 0, 1'b0);

        data_set = 2'd2;
        start    = 1'b1;
        strobes = 0; busy_seen = 0; done_seen = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!en_a || !en_c) strobes++;
            if (busy) busy_seen++;
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("bad_set_strobes", strobes, 0);
        chk("bad_set_busy", busy_seen, 0);
        chk("bad_set_done", done_seen, 0);

        data_set  = 2'd0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!(out_valid && out_index == 6'd20) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_reach_k20", waited < 200, 1);
        chk("rst_strobe_inflight", en_a, 0);
        #2 srst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk_reset_outputs("held_rst");
        srst = 1'b0;
        @(negedge clk);
        sweep(0, 0, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
